zynq_axi3_wr_arbiter: RTL and testbench
=======================================

// Module: zynq_axi3_wr_arbiter
// PURPOSE
//  Shares the single AXI3 write master (m00 AW/W/B) among num_req_p requesters, e.g. the BP DMA and the host loader.
//  Handles one burst at a time: grant, AW issue, W beat streaming, B wait, completion pulse.
//  Sits between the requester engines and the m00_axi_* write ports of the top-level Zynq shell.
//  AR/R channels, awsize, awburst, awcache, awlock, awprot and awqos are tied off outside this block.
// PARAMETERS
//  num_req_p     2   number of requesters; must be >= 2; lg_num_req = $clog2(num_req_p)
//  addr_width_p  32  AXI address width
//  data_width_p  32  AXI data width; wstrb width = data_width_p/8
//  id_width_p    6   AXI ID width; must be >= lg_num_req
// PORTS
//  aclk            in   1                    clock
//  aresetn         in   1                    asynchronous, active-low reset
//  req_v_i         in   num_req_p            per-requester burst request valid
//  req_addr_i      in   num_req_p*addr_w     per-requester burst address (slice i)
//  req_len_i       in   num_req_p*4          per-requester AXI3 len (beats-1)
//  req_yumi_o      out  num_req_p            one-cycle accept of the request (one-hot)
//  wdata_i         in   num_req_p*data_w     per-requester write data
//  wvalid_i        in   num_req_p            per-requester write data valid
//  wready_o        out  num_req_p            per-requester write data ready
//  done_o          out  num_req_p            one-cycle pulse: burst response received
//  done_resp_o     out  2                    bresp captured for the done_o pulse
//  m00_axi_awaddr  out  addr_width_p         AW address
//  m00_axi_awvalid out  1                    AW valid
//  m00_axi_awready in   1                    AW ready
//  m00_axi_awid    out  id_width_p           AW id = granted index, zero-extended
//  m00_axi_awlen   out  4                    AW burst length
//  m00_axi_wdata   out  data_width_p         W data, muxed from the granted requester
//  m00_axi_wvalid  out  1                    W valid
//  m00_axi_wready  in   1                    W ready
//  m00_axi_wid     out  id_width_p           W id = awid
//  m00_axi_wlast   out  1                    last beat of the burst
//  m00_axi_wstrb   out  data_width_p/8       all ones
//  m00_axi_bvalid  in   1                    B valid
//  m00_axi_bready  out  1                    B ready
//  m00_axi_bid     in   id_width_p           B id
//  m00_axi_bresp   in   2                    B response
// BEHAVIOUR
//  - FSM: IDLE -> AW -> W -> B -> IDLE. One outstanding burst. Registered outputs except the W/wready mux path.
//  - Reset (async assert, sync deassert via aclk): state=IDLE, rr_ptr=0, beat_cnt=0. All valid/ready/yumi/done outputs 0.
//    Registered data outputs 0. A reset mid-burst abandons the burst with no done_o.
//  - IDLE: if |req_v_i, grant g = first set bit at or after rr_ptr (wrapping).
//    Pulse req_yumi_o[g] the same cycle. Latch addr, len and g. Next state AW. No request: stay in IDLE.
//  - AW: awvalid=1 with the latched addr, len and id; these hold stable until awready. awvalid&awready -> W, beat_cnt=0.
//  - W: wvalid=wvalid_i[g]; wready_o[g]=m00_axi_wready; wready_o of every other index is 0. wlast=(beat_cnt==len).
//    Each handshake increments beat_cnt. Handshake with wlast -> B. len=0 gives a single beat with wlast=1.
//  - B: bready=1. bvalid&bready -> done_o[g]=1 and done_resp_o=bresp for exactly one cycle.
//    rr_ptr = g+1 (wraps to 0 at num_req_p). -> IDLE. The earliest new grant is the cycle after the done pulse.
//  - A bid != latched id is a protocol error: the response is still consumed. Simulation-only $error.
//  - A requester dropping req_v_i before yumi is legal; that requester is not granted.
//  - Latency: request to awvalid = 1 cycle; B handshake to done_o = same edge (done_o registered, visible next cycle).
// CONFIGURATION
//  ZYNQ_WR_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest set index always wins, and rr_ptr is unused (held 0).
//  Not defined (default): round-robin as described above. Lint checks both builds.
// TESTING
//  1. Reset, then req_v_i=2'b01, addr=0x1000, len=3, slave always ready
//     -> awaddr=0x1000, awlen=3, awid=0; 4 beats with wlast on the 4th; done_o=2'b01, done_resp_o=0.
//  2. req_v_i=2'b11 held for 4 bursts -> grant order 0,1,0,1; awid follows. Fixed-prio build: 0,0,0,0.
//  3. awready held low 5 cycles -> awaddr, awlen and awid stable; wvalid stays 0 until the AW handshake.
//  4. Random wvalid_i/wready stalls, len=15 -> exactly 16 beats; data order preserved; wready_o of the idle requester stays 0.
//  5. bresp=2'b10 on B -> done_resp_o=2'b10 with the done_o pulse; the next grant proceeds normally.
//  6. aresetn deasserted during beat 2 of len=7 -> all outputs 0 asynchronously; no done_o; the next request starts clean at awid=0.

Source files
------------

// File: rtl/zynq_axi3_wr_arbiter_if.sv
// Requester-side and m00 AXI3 write-channel signals shared by zynq_axi3_wr_arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters plus AXI slave.
interface zynq_axi3_wr_arbiter_if #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int id_width_p   = 6
);
    logic [num_req_p-1:0]              req_v_i;
    logic [num_req_p*addr_width_p-1:0] req_addr_i;
    logic [num_req_p*4-1:0]            req_len_i;
    logic [num_req_p-1:0]              req_yumi_o;
    logic [num_req_p*data_width_p-1:0] wdata_i;
    logic [num_req_p-1:0]              wvalid_i;
    logic [num_req_p-1:0]              wready_o;
    logic [num_req_p-1:0]              done_o;
    logic [1:0]                        done_resp_o;

    logic [addr_width_p-1:0]   m00_axi_awaddr;
    logic                      m00_axi_awvalid;
    logic                      m00_axi_awready;
    logic [id_width_p-1:0]     m00_axi_awid;
    logic [3:0]                m00_axi_awlen;
    logic [data_width_p-1:0]   m00_axi_wdata;
    logic                      m00_axi_wvalid;
    logic                      m00_axi_wready;
    logic [id_width_p-1:0]     m00_axi_wid;
    logic                      m00_axi_wlast;
    logic [data_width_p/8-1:0] m00_axi_wstrb;
    logic                      m00_axi_bvalid;
    logic                      m00_axi_bready;
    logic [id_width_p-1:0]     m00_axi_bid;
    logic [1:0]                m00_axi_bresp;

    modport master (
        input  req_v_i, req_addr_i, req_len_i, wdata_i, wvalid_i,
        input  m00_axi_awready, m00_axi_wready, m00_axi_bvalid, m00_axi_bid, m00_axi_bresp,
        output req_yumi_o, wready_o, done_o, done_resp_o,
        output m00_axi_awaddr, m00_axi_awvalid, m00_axi_awid, m00_axi_awlen,
        output m00_axi_wdata, m00_axi_wvalid, m00_axi_wid, m00_axi_wlast, m00_axi_wstrb,
        output m00_axi_bready
    );

    modport slave (
        output req_v_i, req_addr_i, req_len_i, wdata_i, wvalid_i,
        output m00_axi_awready, m00_axi_wready, m00_axi_bvalid, m00_axi_bid, m00_axi_bresp,
        input  req_yumi_o, wready_o, done_o, done_resp_o,
        input  m00_axi_awaddr, m00_axi_awvalid, m00_axi_awid, m00_axi_awlen,
        input  m00_axi_wdata, m00_axi_wvalid, m00_axi_wid, m00_axi_wlast, m00_axi_wstrb,
        input  m00_axi_bready
    );
endinterface

// File: rtl/zynq_axi3_wr_arbiter.sv
// Shares the m00 AXI3 write master among num_req_p requesters, one burst at a time.
// Define ZYNQ_WR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module zynq_axi3_wr_arbiter #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int id_width_p   = 6
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    zynq_axi3_wr_arbiter_if.master bus
);
    localparam int LgNumReq = $clog2(num_req_p);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } state_e;

    state_e                  state_q, state_d;
    logic [LgNumReq-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LgNumReq-1:0]     gnt_q, gnt_d;
    logic [LgNumReq-1:0]     pick;
    logic                    pick_v;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [3:0]              beat_cnt_q, beat_cnt_d;
    logic [num_req_p-1:0]    done_q, done_d;
    logic [1:0]              done_resp_q, done_resp_d;
    logic                    in_w;
    logic                    w_hs;

    // First requesting index at or after rr_ptr_q, wrapping; rr_ptr_q stays 0 in fixed-priority builds.
    always_comb begin
        int idx;
        pick   = '0;
        pick_v = 1'b0;
        idx    = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!pick_v && bus.req_v_i[idx]) begin
                pick   = LgNumReq'(idx);
                pick_v = 1'b1;
            end
        end
    end

    assign in_w = (state_q == ST_W);
    assign w_hs = bus.m00_axi_wvalid && bus.m00_axi_wready;

    assign bus.m00_axi_awvalid = (state_q == ST_AW);
    assign bus.m00_axi_awaddr  = addr_q;
    assign bus.m00_axi_awlen   = len_q;
    assign bus.m00_axi_awid    = id_width_p'(gnt_q);
    assign bus.m00_axi_wid     = id_width_p'(gnt_q);
    assign bus.m00_axi_wstrb   = '1;
    assign bus.m00_axi_wlast   = in_w && (beat_cnt_q == len_q);
    assign bus.m00_axi_wvalid  = in_w && bus.wvalid_i[gnt_q];
    assign bus.m00_axi_wdata   = in_w ? bus.wdata_i[int'(gnt_q)*data_width_p +: data_width_p] : '0;
    assign bus.m00_axi_bready  = (state_q == ST_B);
    assign bus.done_o          = done_q;
    assign bus.done_resp_o     = done_resp_q;

    always_comb begin
        bus.wready_o = '0;
        if (in_w) bus.wready_o[gnt_q] = bus.m00_axi_wready;
    end

    // No grant while the previous done pulse is visible, so a new grant never overlaps done_o.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        addr_d         = addr_q;
        len_d          = len_q;
        beat_cnt_d     = beat_cnt_q;
        done_d         = '0;
        done_resp_d    = '0;
        bus.req_yumi_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (aresetn && pick_v && !(|done_q)) begin
                    bus.req_yumi_o[pick] = 1'b1;
                    gnt_d   = pick;
                    addr_d  = bus.req_addr_i[int'(pick)*addr_width_p +: addr_width_p];
                    len_d   = bus.req_len_i[int'(pick)*4 +: 4];
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (bus.m00_axi_awready) begin
                    beat_cnt_d = '0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (bus.m00_axi_wlast) state_d = ST_B;
                end
            end
            ST_B: begin
                if (bus.m00_axi_bvalid) begin
                    done_d[gnt_q] = 1'b1;
                    done_resp_d   = bus.m00_axi_bresp;
                    state_d       = ST_IDLE;
`ifdef ZYNQ_WR_ARB_FIXED_PRIO_EN
                    rr_ptr_d      = '0;
`else
                    rr_ptr_d      = (gnt_q == LgNumReq'(num_req_p - 1)) ? '0 : gnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            done_q      <= '0;
            done_resp_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

`ifndef SYNTHESIS
    // A mismatched bid is still consumed; it is only flagged in simulation.
    always @(posedge aclk) begin
        if (aresetn && state_q == ST_B && bus.m00_axi_bvalid && bus.m00_axi_bid != bus.m00_axi_awid)
            $error("zynq_axi3_wr_arbiter: bid %0h does not match awid %0h",
                   bus.m00_axi_bid, bus.m00_axi_awid);
    end
`endif
endmodule

// File: tb/tb_zynq_axi3_wr_arbiter.sv
// Directed self-checking bench for zynq_axi3_wr_arbiter: single bursts, arbitration order,
// AW back-pressure, W stalls, error responses and mid-burst reset.
module tb_zynq_axi3_wr_arbiter;
    localparam int NumReq = 2;
    localparam int AddrW  = 32;
    localparam int DataW  = 32;
    localparam int IdW    = 6;
`ifdef ZYNQ_WR_ARB_FIXED_PRIO_EN
    localparam int RrEn = 0;
`else
    localparam int RrEn = 1;
`endif

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    zynq_axi3_wr_arbiter_if #(
        .num_req_p(NumReq), .addr_width_p(AddrW), .data_width_p(DataW), .id_width_p(IdW)
    ) bus ();

    zynq_axi3_wr_arbiter #(
        .num_req_p(NumReq), .addr_width_p(AddrW), .data_width_p(DataW), .id_width_p(IdW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    // Inputs change and outputs are sampled 1-2 time units after the rising edge.
    task automatic stepCycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        compared++;
        mismatched++;
        $error("[TB] FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    function automatic logic [31:0] beatData(input int g, input int k);
        return 32'hA500_0000 | (32'(g) << 16) | 32'(k);
    endfunction

    task automatic applyIdle();
        bus.req_v_i         = '0;
        bus.req_addr_i      = '0;
        bus.req_len_i       = '0;
        bus.wdata_i         = '0;
        bus.wvalid_i        = '0;
        bus.m00_axi_awready = 1'b0;
        bus.m00_axi_wready  = 1'b0;
        bus.m00_axi_bvalid  = 1'b0;
        bus.m00_axi_bid     = '0;
        bus.m00_axi_bresp   = '0;
    endtask

    // The expected grantee gets addr/len; every other requester gets decoy values.
    task automatic applyStimulus(input logic [1:0] reqV, input int gnt,
                                 input logic [31:0] addr, input logic [3:0] len);
        bus.req_v_i = reqV;
        for (int r = 0; r < NumReq; r++) begin
            bus.req_addr_i[r*AddrW +: AddrW] = (r == gnt) ? addr : ~addr;
            bus.req_len_i[r*4 +: 4]          = (r == gnt) ? len : ~len;
        end
        #1;
    endtask

    task automatic doReset();
        applyIdle();
        aresetn = 1'b0;
        stepCycle();
        stepCycle();
        aresetn = 1'b1;
        stepCycle();
    endtask

    task automatic runBurst(input string tag, input logic [1:0] reqV, input int expGnt,
                            input logic [31:0] addr, input logic [3:0] len, input int awDelay,
                            input bit stalls, input logic [1:0] bresp, input int resetAtBeat);
        int         other;
        int         waitCnt;
        int         k;
        int         budget;
        logic       wv;
        logic       wr;
        logic [1:0] gntMask;
        other   = 1 - expGnt;
        gntMask = 2'b01 << expGnt;

        applyStimulus(reqV, expGnt, addr, len);
        waitCnt = 0;
        while (bus.req_yumi_o == '0 && waitCnt < 8) begin
            stepCycle();
            waitCnt++;
        end
        if (bus.req_yumi_o == '0) begin
            reportTimeout({tag, "_yumi"});
            bus.req_v_i = '0;
            return;
        end
        checkOutput({tag, "_yumi"}, 64'(bus.req_yumi_o), 64'(gntMask));
        checkOutput({tag, "_awvalid_pre"}, 64'(bus.m00_axi_awvalid), 64'd0);

        stepCycle();
        bus.req_v_i         = '0;
        bus.wvalid_i        = '1;
        bus.wdata_i[other*DataW +: DataW] = 32'hDEAD_BEEF;
        #1;
        for (int d = 0; d < awDelay; d++) begin
            checkOutput({tag, "_aw_hold_addr"}, 64'(bus.m00_axi_awaddr), 64'(addr));
            checkOutput({tag, "_aw_hold_len"},  64'(bus.m00_axi_awlen), 64'(len));
            checkOutput({tag, "_aw_hold_id"},   64'(bus.m00_axi_awid), 64'(expGnt));
            checkOutput({tag, "_aw_hold_wvalid"}, 64'(bus.m00_axi_wvalid), 64'd0);
            stepCycle();
        end
        bus.m00_axi_awready = 1'b1;
        #1;
        checkOutput({tag, "_awvalid"}, 64'(bus.m00_axi_awvalid), 64'd1);
        checkOutput({tag, "_awaddr"},  64'(bus.m00_axi_awaddr), 64'(addr));
        checkOutput({tag, "_awlen"},   64'(bus.m00_axi_awlen), 64'(len));
        checkOutput({tag, "_awid"},    64'(bus.m00_axi_awid), 64'(expGnt));
        checkOutput({tag, "_aw_wvalid"}, 64'(bus.m00_axi_wvalid), 64'd0);
        stepCycle();
        bus.m00_axi_awready = 1'b0;

        k      = 0;
        budget = 0;
        while (k <= int'(len) && budget < 200) begin
            if (k == resetAtBeat) begin
                bus.wvalid_i[expGnt] = 1'b1;
                bus.wdata_i[expGnt*DataW +: DataW] = beatData(expGnt, k);
                bus.m00_axi_wready = 1'b1;
                bus.req_v_i        = 2'b11;
                #1;
                aresetn = 1'b0;
                #1;
                checkOutput({tag, "_rst_awvalid"}, 64'(bus.m00_axi_awvalid), 64'd0);
                checkOutput({tag, "_rst_wvalid"},  64'(bus.m00_axi_wvalid), 64'd0);
                checkOutput({tag, "_rst_wlast"},   64'(bus.m00_axi_wlast), 64'd0);
                checkOutput({tag, "_rst_wdata"},   64'(bus.m00_axi_wdata), 64'd0);
                checkOutput({tag, "_rst_wready_o"}, 64'(bus.wready_o), 64'd0);
                checkOutput({tag, "_rst_bready"},  64'(bus.m00_axi_bready), 64'd0);
                checkOutput({tag, "_rst_yumi"},    64'(bus.req_yumi_o), 64'd0);
                checkOutput({tag, "_rst_done"},    64'(bus.done_o), 64'd0);
                checkOutput({tag, "_rst_awaddr"},  64'(bus.m00_axi_awaddr), 64'd0);
                checkOutput({tag, "_rst_awid"},    64'(bus.m00_axi_awid), 64'd0);
                stepCycle();
                applyIdle();
                aresetn = 1'b1;
                stepCycle();
                checkOutput({tag, "_post_rst_done"}, 64'(bus.done_o), 64'd0);
                stepCycle();
                checkOutput({tag, "_post_rst_done2"}, 64'(bus.done_o), 64'd0);
                checkOutput({tag, "_post_rst_awvalid"}, 64'(bus.m00_axi_awvalid), 64'd0);
                return;
            end
            wv = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            wr = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wvalid_i[expGnt] = wv;
            bus.wdata_i[expGnt*DataW +: DataW] = beatData(expGnt, k);
            bus.m00_axi_wready = wr;
            #1;
            checkOutput({tag, "_wvalid"},   64'(bus.m00_axi_wvalid), 64'(wv));
            checkOutput({tag, "_wready_o"}, 64'(bus.wready_o), wr ? 64'(gntMask) : 64'd0);
            checkOutput({tag, "_wlast"},    64'(bus.m00_axi_wlast), 64'(k == int'(len)));
            checkOutput({tag, "_wid"},      64'(bus.m00_axi_wid), 64'(expGnt));
            if (wv && wr)
                checkOutput({tag, "_wdata"}, 64'(bus.m00_axi_wdata), 64'(beatData(expGnt, k)));
            stepCycle();
            if (wv && wr) k++;
            budget++;
        end
        if (k <= int'(len)) begin
            reportTimeout({tag, "_wbeats"});
            return;
        end

        bus.wvalid_i       = '0;
        bus.m00_axi_wready = 1'b0;
        #1;
        checkOutput({tag, "_bready"},   64'(bus.m00_axi_bready), 64'd1);
        checkOutput({tag, "_b_wvalid"}, 64'(bus.m00_axi_wvalid), 64'd0);
        bus.m00_axi_bvalid = 1'b1;
        bus.m00_axi_bid    = IdW'(expGnt);
        bus.m00_axi_bresp  = bresp;
        #1;
        checkOutput({tag, "_done_early"}, 64'(bus.done_o), 64'd0);
        stepCycle();
        bus.m00_axi_bvalid = 1'b0;
        bus.m00_axi_bresp  = '0;
        bus.req_v_i        = 2'b11;
        #1;
        checkOutput({tag, "_done"},      64'(bus.done_o), 64'(gntMask));
        checkOutput({tag, "_done_resp"}, 64'(bus.done_resp_o), 64'(bresp));
        checkOutput({tag, "_b_bready"},  64'(bus.m00_axi_bready), 64'd0);
        checkOutput({tag, "_no_gnt_on_done"}, 64'(bus.req_yumi_o), 64'd0);
        bus.req_v_i = '0;
        stepCycle();
        checkOutput({tag, "_done_clr"},      64'(bus.done_o), 64'd0);
        checkOutput({tag, "_done_resp_clr"}, 64'(bus.done_resp_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyIdle();
        aresetn     = 1'b0;
        bus.req_v_i = 2'b01;
        #1;
        checkOutput("reset_yumi",    64'(bus.req_yumi_o), 64'd0);
        checkOutput("reset_awvalid", 64'(bus.m00_axi_awvalid), 64'd0);
        checkOutput("reset_wvalid",  64'(bus.m00_axi_wvalid), 64'd0);
        checkOutput("reset_bready",  64'(bus.m00_axi_bready), 64'd0);
        checkOutput("reset_done",    64'(bus.done_o), 64'd0);
        checkOutput("reset_awaddr",  64'(bus.m00_axi_awaddr), 64'd0);
        checkOutput("reset_wstrb",   64'(bus.m00_axi_wstrb), 64'hF);
        bus.req_v_i = '0;
        stepCycle();
        stepCycle();
        aresetn = 1'b1;
        stepCycle();

        $display("[TB] single burst, len 3");
        runBurst("t1", 2'b01, 0, 32'h0000_1000, 4'd3, 0, 1'b0, 2'b00, -1);

        $display("[TB] both requesting for four bursts");
        doReset();
        for (int i = 0; i < 4; i++)
            runBurst($sformatf("t2_%0d", i), 2'b11, (RrEn != 0) ? (i % 2) : 0,
                     32'h0000_3000 + 32'(i * 16), 4'(i), 0, 1'b0, 2'b00, -1);

        $display("[TB] awready held low");
        runBurst("t3", 2'b10, 1, 32'h0000_2000, 4'd2, 5, 1'b0, 2'b00, -1);

        $display("[TB] len 15 with random stalls");
        runBurst("t4", 2'b01, 0, 32'h0000_4000, 4'd15, 1, 1'b1, 2'b00, -1);

        $display("[TB] SLVERR response then normal burst");
        runBurst("t5a", 2'b10, 1, 32'h0000_5000, 4'd1, 0, 1'b0, 2'b10, -1);
        runBurst("t5b", 2'b01, 0, 32'h0000_5100, 4'd0, 0, 1'b0, 2'b00, -1);

        $display("[TB] reset during beat 2 of len 7");
        runBurst("t6", 2'b10, 1, 32'h0000_6000, 4'd7, 0, 1'b0, 2'b00, 2);
        runBurst("t6_after", 2'b11, 0, 32'h0000_7000, 4'd1, 0, 1'b0, 2'b00, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
